// File: rtl/z80_snd_mem_arb.sv
// Sound-ROM port scheduler: one outstanding read shared by the Z80 and both YM2610 ADPCM fetchers.
// ADPCM requesters that wait too long are promoted above the Z80 so playback cannot underrun.
module z80_snd_mem_arb #(
    parameter int ADDR_W     = 24,
    parameter int STARVE_MAX = 15,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              i_Z80_REQ,
    input  logic [ADDR_W-1:0] i_Z80_ADDR,
    output logic [7:0]        o_Z80_DATA,
    output logic              o_Z80_ACK,
    output logic              o_Z80_nWAIT,
    input  logic              i_ADA_REQ,
    input  logic [ADDR_W-1:0] i_ADA_ADDR,
    output logic [7:0]        o_ADA_DATA,
    output logic              o_ADA_ACK,
    input  logic              i_ADB_REQ,
    input  logic [ADDR_W-1:0] i_ADB_ADDR,
    output logic [7:0]        o_ADB_DATA,
    output logic              o_ADB_ACK,
    output logic              o_MEM_REQ,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    input  logic              i_MEM_RDY,
    input  logic [15:0]       i_MEM_DATA,
    output logic              o_TMO_ERR
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_grant;
    logic [2:0]        r_ack;
    logic [2:0]        r_ackPrev;
    logic [2:0]        w_req;
    logic [2:0]        w_elig;
    logic [2:0]        w_sel;
    logic              w_done;
    logic              w_tmo;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_selAddr;
    logic [TW-1:0]     r_tmoCnt;
    logic [SW-1:0]     r_adaCnt;
    logic [SW-1:0]     r_adbCnt;
    logic              r_z80Done;
    logic              r_tmoErr;
    logic [7:0]        r_z80Data;
    logic [7:0]        r_adaData;
    logic [7:0]        r_adbData;
    logic [7:0]        w_byte;

    // Bit order everywhere: [0]=Z80, [1]=ADA, [2]=ADB. A requester is blind for its ACK cycle and the one after.
    assign w_req  = {i_ADB_REQ, i_ADA_REQ, i_Z80_REQ};
    assign w_elig = w_req & ~r_ack & ~r_ackPrev & {2'b11, ~r_z80Done};
    assign w_byte = w_tmo ? 8'hFF : (r_addr[0] ? i_MEM_DATA[15:8] : i_MEM_DATA[7:0]);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_sel  = 3'b000;
        w_done = 1'b0;
        w_tmo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig[1] && (r_adaCnt == STARVE_SAT)) begin
                    w_sel = 3'b010;
                end else if (w_elig[2] && (r_adbCnt == STARVE_SAT)) begin
                    w_sel = 3'b100;
                end else if (w_elig[0]) begin
                    w_sel = 3'b001;
                end else if (w_elig[1]) begin
                    w_sel = 3'b010;
                end else if (w_elig[2]) begin
                    w_sel = 3'b100;
                end
                if (w_sel != 3'b000) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_MEM_RDY) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (r_tmoCnt == TMO_LAST) begin
                    w_done = 1'b1;
                    w_tmo  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_selAddr = i_Z80_ADDR;
        if (w_sel[1]) begin
            w_selAddr = i_ADA_ADDR;
        end else if (w_sel[2]) begin
            w_selAddr = i_ADB_ADDR;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_grant   <= 3'b000;
            r_ack     <= 3'b000;
            r_ackPrev <= 3'b000;
            r_addr    <= '0;
            r_tmoCnt  <= '0;
            r_adaCnt  <= '0;
            r_adbCnt  <= '0;
            r_z80Done <= 1'b0;
            r_tmoErr  <= 1'b0;
            r_z80Data <= 8'h00;
            r_adaData <= 8'h00;
            r_adbData <= 8'h00;
        end else begin
            r_ackPrev <= r_ack;
            r_ack     <= w_done ? r_grant : 3'b000;
            if (w_sel != 3'b000) begin
                r_grant <= w_sel;
                r_addr  <= w_selAddr;
            end
            r_tmoCnt <= (r_state == S_IDLE) ? '0 : r_tmoCnt + TW'(1);
            if (w_done && r_grant[0]) r_z80Data <= w_byte;
            if (w_done && r_grant[1]) r_adaData <= w_byte;
            if (w_done && r_grant[2]) r_adbData <= w_byte;
            if (w_tmo) r_tmoErr <= 1'b1;
            if (!i_Z80_REQ) begin
                r_z80Done <= 1'b0;
            end else if (r_ack[0]) begin
                r_z80Done <= 1'b1;
            end
            // Waiting time excludes the requester's own transaction in flight.
            if (w_sel[1]) begin
                r_adaCnt <= '0;
            end else if (i_ADA_REQ && !(r_state != S_IDLE && r_grant[1]) && r_adaCnt != STARVE_SAT) begin
                r_adaCnt <= r_adaCnt + SW'(1);
            end
            if (w_sel[2]) begin
                r_adbCnt <= '0;
            end else if (i_ADB_REQ && !(r_state != S_IDLE && r_grant[2]) && r_adbCnt != STARVE_SAT) begin
                r_adbCnt <= r_adbCnt + SW'(1);
            end
        end
    end

    assign o_MEM_REQ   = (r_state == S_ISSUE);
    assign o_MEM_ADDR  = {r_addr[ADDR_W-1:1], 1'b0};
    assign o_Z80_ACK   = r_ack[0];
    assign o_ADA_ACK   = r_ack[1];
    assign o_ADB_ACK   = r_ack[2];
    assign o_Z80_DATA  = r_z80Data;
    assign o_ADA_DATA  = r_adaData;
    assign o_ADB_DATA  = r_adbData;
    assign o_TMO_ERR   = r_tmoErr;
    assign o_Z80_nWAIT = ~(i_Z80_REQ & ~(r_z80Done | r_ack[0]));

endmodule
